// File: rtl/pkt_arb_pkg.sv
// Shared encodings and helpers for the packet round-robin arbiter.
package pkt_arb_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    // Ceiling log2, minimum 1 so a 2-port arbiter still gets a 1-bit grant.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((64'd1 << r) < 64'(n)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority encoder: first requester after last_grant, modulo C_NUM_PORTS.
module rr_pick
    import pkt_arb_pkg::*;
#(
    parameter int unsigned C_NUM_PORTS = 4,
    parameter int unsigned C_GRANT_W   = clog2(C_NUM_PORTS)
) (
    input  logic [C_NUM_PORTS-1:0] req,
    input  logic [C_GRANT_W-1:0]   last_grant,
    output logic                   found,
    output logic [C_GRANT_W-1:0]   pick_id
);

    always_comb begin
        int unsigned idx;
        idx     = 0;
        found   = 1'b0;
        pick_id = '0;
        for (int unsigned k = 1; k <= C_NUM_PORTS; k++) begin
            idx = (32'(last_grant) + k) % C_NUM_PORTS;
            if (!found && req[idx]) begin
                found   = 1'b1;
                pick_id = idx[C_GRANT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pkt_rr_arbiter.sv
// Packet-level round-robin arbiter merging C_NUM_PORTS AXI-Stream queues into one egress stream.
// Per-port packet counters are built only when PKT_ARB_STATS_EN is defined.
module pkt_rr_arbiter
    import pkt_arb_pkg::*;
#(
    parameter int unsigned C_NUM_PORTS  = 4,
    parameter int unsigned C_DATA_WIDTH = 8,
    parameter int unsigned C_MTY_WIDTH  = 8,
    parameter int unsigned C_CNT_WIDTH  = 16,
    parameter int unsigned C_GRANT_W    = clog2(C_NUM_PORTS)
) (
    input  logic                                aclk,
    input  logic                                areset,
    input  logic [C_NUM_PORTS-1:0]              s_axis_tvalid,
    input  logic [C_NUM_PORTS*C_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [C_NUM_PORTS-1:0]              s_axis_tlast,
    input  logic [C_NUM_PORTS*C_MTY_WIDTH-1:0]  s_axis_tuser_mty,
    output logic [C_NUM_PORTS-1:0]              s_axis_tready,
    output logic                                m_axis_tvalid,
    output logic [C_DATA_WIDTH-1:0]             m_axis_tdata,
    output logic                                m_axis_tlast,
    output logic [C_MTY_WIDTH-1:0]              m_axis_tuser_mty,
    input  logic                                m_axis_tready,
    output logic [C_GRANT_W-1:0]                grant_id,
    output logic                                busy,
    output logic [C_NUM_PORTS*C_CNT_WIDTH-1:0]  pkt_cnt
);

    logic                 state_q, state_d;
    logic [C_GRANT_W-1:0] grant_q, grant_d;
    logic [C_GRANT_W-1:0] last_q, last_d;
    logic                 found;
    logic [C_GRANT_W-1:0] pick_id;
    logic                 xfer_last;

    rr_pick #(
        .C_NUM_PORTS (C_NUM_PORTS),
        .C_GRANT_W   (C_GRANT_W)
    ) u_rr_pick (
        .req        (s_axis_tvalid),
        .last_grant (last_q),
        .found      (found),
        .pick_id    (pick_id)
    );

    // Pure pass-through of the granted port while busy; everything quiet in idle.
    always_comb begin
        m_axis_tvalid    = 1'b0;
        m_axis_tdata     = '0;
        m_axis_tlast     = 1'b0;
        m_axis_tuser_mty = '0;
        s_axis_tready    = '0;
        busy             = 1'b0;
        if (state_q == ST_BUSY) begin
            m_axis_tvalid          = s_axis_tvalid[grant_q];
            m_axis_tdata           = s_axis_tdata[32'(grant_q)*C_DATA_WIDTH +: C_DATA_WIDTH];
            m_axis_tlast           = s_axis_tlast[grant_q];
            m_axis_tuser_mty       = s_axis_tuser_mty[32'(grant_q)*C_MTY_WIDTH +: C_MTY_WIDTH];
            s_axis_tready[grant_q] = m_axis_tready;
            busy                   = 1'b1;
        end
    end

    assign xfer_last = busy && m_axis_tvalid && m_axis_tready && m_axis_tlast;
    assign grant_id  = grant_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (state_q == ST_IDLE) begin
            if (found) begin
                grant_d = pick_id;
                state_d = ST_BUSY;
            end
        end else if (xfer_last) begin
            last_d  = grant_q;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= C_GRANT_W'(C_NUM_PORTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

`ifdef PKT_ARB_STATS_EN
    logic [C_NUM_PORTS*C_CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (xfer_last) begin
            cnt_d[32'(grant_q)*C_CNT_WIDTH +: C_CNT_WIDTH] =
                cnt_q[32'(grant_q)*C_CNT_WIDTH +: C_CNT_WIDTH] + C_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pkt_cnt = cnt_q;
`else
    assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Self-checking bench for pkt_rr_arbiter: per-port packet queues, packet-level round-robin model.
module tb_pkt_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MW = 8;
    localparam int CW = 16;

    logic            aclk = 1'b0;
    logic            areset;
    logic [N-1:0]    s_tvalid, s_tlast, s_tready;
    logic [N*DW-1:0] s_tdata;
    logic [N*MW-1:0] s_mty;
    logic            m_tvalid, m_tlast, m_tready;
    logic [DW-1:0]   m_tdata;
    logic [MW-1:0]   m_mty;
    logic [1:0]      grant_id;
    logic            busy;
    logic [N*CW-1:0] pkt_cnt;

    always #5 aclk = ~aclk;

    pkt_rr_arbiter #(
        .C_NUM_PORTS  (N),
        .C_DATA_WIDTH (DW),
        .C_MTY_WIDTH  (MW),
        .C_CNT_WIDTH  (CW)
    ) dut (
        .aclk             (aclk),
        .areset           (areset),
        .s_axis_tvalid    (s_tvalid),
        .s_axis_tdata     (s_tdata),
        .s_axis_tlast     (s_tlast),
        .s_axis_tuser_mty (s_mty),
        .s_axis_tready    (s_tready),
        .m_axis_tvalid    (m_tvalid),
        .m_axis_tdata     (m_tdata),
        .m_axis_tlast     (m_tlast),
        .m_axis_tuser_mty (m_mty),
        .m_axis_tready    (m_tready),
        .grant_id         (grant_id),
        .busy             (busy),
        .pkt_cnt          (pkt_cnt)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [MW-1:0] mty;
    } beat_t;

    beat_t        q[N][$];
    logic [N-1:0] en, hold;
    logic         rst_req;
    bit           chk_en;
    int           rdy_mode;
    int           cyc;
    int           checks, errors;
    int           loaded_beats, beats_out;

    // Packet-level reference state
    bit           mdl_busy;
    int           mdl_grant, mdl_last;
    int           mdl_cnt[N];
    int           grant_log[$];

    function automatic int rr_next(input int last, input logic [N-1:0] req);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic mdl_reset();
        mdl_busy  = 1'b0;
        mdl_grant = 0;
        mdl_last  = N - 1;
        for (int i = 0; i < N; i++) mdl_cnt[i] = 0;
    endtask

    task automatic load(input int p, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = DW'($urandom);
            b.last = (k == len - 1);
            b.mty  = MW'($urandom);
            q[p].push_back(b);
        end
        loaded_beats += len;
    endtask

    // One clock: drive at negedge, check outputs 1ns later, then advance the model.
    task automatic step();
        logic [N-1:0]    exp_ready;
        logic            exp_valid;
        logic [N*CW-1:0] exp_cnt;
        beat_t           b;
        @(negedge aclk);
        cyc++;
        areset = rst_req;
        for (int i = 0; i < N; i++) begin
            if (en[i] && !hold[i] && q[i].size() > 0) begin
                s_tvalid[i]          = 1'b1;
                s_tdata[i*DW +: DW]  = q[i][0].data;
                s_tlast[i]           = q[i][0].last;
                s_mty[i*MW +: MW]    = q[i][0].mty;
            end else begin
                s_tvalid[i]          = 1'b0;
                s_tdata[i*DW +: DW]  = DW'($urandom);
                s_tlast[i]           = 1'($urandom);
                s_mty[i*MW +: MW]    = MW'($urandom);
            end
        end
        case (rdy_mode)
            1:       m_tready = (cyc % 2 == 0);
            2:       m_tready = ($urandom % 4 != 0);
            default: m_tready = 1'b1;
        endcase
        #1;
        exp_ready = (mdl_busy && m_tready) ? N'(1 << mdl_grant) : '0;
        exp_valid = mdl_busy && s_tvalid[mdl_grant];
        exp_cnt   = '0;
`ifdef PKT_ARB_STATS_EN
        for (int i = 0; i < N; i++) exp_cnt[i*CW +: CW] = CW'(mdl_cnt[i]);
`endif
        if (chk_en) begin
            checks++;
            if (m_tvalid !== exp_valid) begin
                errors++;
                $display("FAIL m_tvalid cyc=%0d got=%b exp=%b", cyc, m_tvalid, exp_valid);
            end
            checks++;
            if (s_tready !== exp_ready) begin
                errors++;
                $display("FAIL s_tready cyc=%0d got=%b exp=%b", cyc, s_tready, exp_ready);
            end
            checks++;
            if (busy !== mdl_busy) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, mdl_busy);
            end
            checks++;
            if (grant_id !== 2'(mdl_grant)) begin
                errors++;
                $display("FAIL grant_id cyc=%0d got=%0d exp=%0d", cyc, grant_id, mdl_grant);
            end
            checks++;
            if (pkt_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL pkt_cnt cyc=%0d got=%h exp=%h", cyc, pkt_cnt, exp_cnt);
            end
            if (exp_valid) begin
                b = q[mdl_grant][0];
                checks++;
                if ({m_tdata, m_tlast, m_mty} !== {b.data, b.last, b.mty}) begin
                    errors++;
                    $display("FAIL beat cyc=%0d got=%h/%b/%h exp=%h/%b/%h", cyc,
                             m_tdata, m_tlast, m_mty, b.data, b.last, b.mty);
                end
            end
        end
        if (rst_req) begin
            mdl_reset();
        end else if (!mdl_busy) begin
            if (|s_tvalid) begin
                mdl_grant = rr_next(mdl_last, s_tvalid);
                mdl_busy  = 1'b1;
                grant_log.push_back(mdl_grant);
            end
        end else if (s_tvalid[mdl_grant] && m_tready) begin
            b = q[mdl_grant].pop_front();
            beats_out++;
            if (b.last) begin
                mdl_last = mdl_grant;
                mdl_busy = 1'b0;
                mdl_cnt[mdl_grant]++;
            end
        end
    endtask

    task automatic drain(input int budget, output int used);
        bit pending;
        used = 0;
        en   = '1;
        hold = '0;
        pending = 1'b1;
        while (pending && used < budget) begin
            step();
            used++;
            pending = mdl_busy;
            for (int i = 0; i < N; i++) if (q[i].size() > 0) pending = 1'b1;
        end
        checks++;
        if (pending) begin
            errors++;
            $display("FAIL drain_timeout got=%0d cycles exp=<%0d", used, budget);
        end
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        for (int i = 0; i < N; i++) q[i].delete();
        grant_log.delete();
    endtask

    task automatic test_reset();
        chk_en  = 1'b0;
        rst_req = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        rst_req = 1'b0;
        en = '0;
        for (int c = 0; c < 20; c++) begin
            step();
            checks++;
            if ({m_tvalid, s_tready, busy, grant_id} !== '0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%b/%b/%b/%0d exp=0/0/0/0", cyc,
                         m_tvalid, s_tready, busy, grant_id);
            end
        end
    endtask

    task automatic test_all_ports();
        int used, b0;
        grant_log.delete();
        b0 = beats_out;
        for (int p = 0; p < N; p++) load(p, 4);
        rdy_mode = 0;
        drain(60, used);
        checks++;
        if (used !== 20 || beats_out - b0 !== 16) begin
            errors++;
            $display("FAIL all_ports_timing got=%0d cyc/%0d beats exp=20/16", used, beats_out - b0);
        end
        checks++;
        if (grant_log.size() != 4 || grant_log[0] != 0 || grant_log[1] != 1 ||
            grant_log[2] != 2 || grant_log[3] != 3) begin
            errors++;
            $display("FAIL all_ports_order got=%p exp=0,1,2,3", grant_log);
        end
    endtask

    task automatic test_alternate();
        int used, expc;
        bit ok;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            load(1, 2);
            load(3, 2);
        end
        rdy_mode = 0;
        drain(80, used);
        ok = (grant_log.size() == 10);
        for (int k = 0; k < grant_log.size(); k++) if (grant_log[k] != ((k % 2) ? 3 : 1)) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL alternate_order got=%p exp=1,3 repeated x5", grant_log);
        end
`ifdef PKT_ARB_STATS_EN
        expc = 5;
`else
        expc = 0;
`endif
        checks++;
        if (pkt_cnt[1*CW +: CW] !== CW'(expc) || pkt_cnt[3*CW +: CW] !== CW'(expc)) begin
            errors++;
            $display("FAIL alternate_cnt got=%0d/%0d exp=%0d/%0d", pkt_cnt[1*CW +: CW],
                     pkt_cnt[3*CW +: CW], expc, expc);
        end
    endtask

    task automatic test_backpressure();
        int used, b0, guard;
        bit p0_ready;
        grant_log.delete();
        b0 = beats_out;
        rdy_mode = 1;
        en = 4'b0100;
        load(2, 6);
        step();
        load(0, 4);
        en = 4'b0101;
        p0_ready = 1'b0;
        guard = 0;
        while (mdl_busy && mdl_grant == 2 && guard < 40) begin
            step();
            if (s_tready[0] !== 1'b0) p0_ready = 1'b1;
            guard++;
        end
        checks++;
        if (p0_ready) begin
            errors++;
            $display("FAIL bp_port0_ready got=1 exp=0 while port 2 granted");
        end
        drain(60, used);
        checks++;
        if (grant_log.size() != 2 || grant_log[0] != 2 || grant_log[1] != 0 ||
            beats_out - b0 != 10) begin
            errors++;
            $display("FAIL bp_order got=%p beats=%0d exp=2,0 beats=10", grant_log, beats_out - b0);
        end
    endtask

    task automatic test_stall();
        int used, guard;
        rdy_mode = 0;
        en = 4'b0010;
        load(1, 8);
        guard = 0;
        while (q[1].size() > 5 && guard < 20) begin
            step();
            guard++;
        end
        hold[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (m_tvalid !== 1'b0 || grant_id !== 2'd1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall cyc=%0d got=v%b g%0d b%b exp=v0 g1 b1", cyc, m_tvalid,
                         grant_id, busy);
            end
        end
        drain(40, used);
        checks++;
        if (mdl_cnt[1] == 0 || q[1].size() != 0) begin
            errors++;
            $display("FAIL stall_resume got=%0d left exp=0 left", q[1].size());
        end
    endtask

    task automatic test_reset_mid();
        int used, guard;
        rdy_mode = 0;
        en = 4'b0100;
        load(2, 8);
        guard = 0;
        while (q[2].size() > 6 && guard < 20) begin
            step();
            guard++;
        end
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        q[2].delete();
        step();
        checks++;
        if ({m_tvalid, s_tready, busy, grant_id} !== '0) begin
            errors++;
            $display("FAIL reset_mid got=%b/%b/%b/%0d exp=0/0/0/0", m_tvalid, s_tready, busy,
                     grant_id);
        end
        grant_log.delete();
        for (int p = 0; p < N; p++) load(p, 2);
        drain(40, used);
        checks++;
        if (grant_log.size() == 0 || grant_log[0] != 0) begin
            errors++;
            $display("FAIL reset_mid_first_grant got=%p exp=0 first", grant_log);
        end
    endtask

    task automatic test_random();
        int used, l0, b0;
        do_reset();
        l0 = loaded_beats;
        b0 = beats_out;
        rdy_mode = 2;
        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < N; p++) begin
                if (q[p].size() == 0 && $urandom % 6 == 0) load(p, 1 + int'($urandom % 6));
                en[p]   = ($urandom % 8 != 0);
                hold[p] = ($urandom % 8 == 0);
            end
            step();
        end
        drain(600, used);
        checks++;
        if (beats_out - b0 != loaded_beats - l0) begin
            errors++;
            $display("FAIL random_beats got=%0d exp=%0d", beats_out - b0, loaded_beats - l0);
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        loaded_beats = 0; beats_out = 0;
        en = '0; hold = '0; rdy_mode = 0;
        rst_req = 1'b1; areset = 1'b1; chk_en = 1'b0;
        s_tvalid = '0; s_tdata = '0; s_tlast = '0; s_mty = '0; m_tready = 1'b0;
        mdl_reset();
        test_reset();
        test_all_ports();
        test_alternate();
        test_backpressure();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
